rect_draw_engine: RTL and testbench
===================================

Name: rect_draw_engine

Overview:
- Drawing engine that sits directly upstream of the video controller.
- Accepts rectangle-fill commands on a 400x300, 3-bit-colour map and emits the pixel write stream (wdata, waddr, we) into the back buffer.
- Applies the raster write mode (replace/and/or/xor) by read-modify-write through the back-buffer read port.
- Issues the buffer-swap (flush) pulse, aligned to the end of frame.

Parameters:
- MAP_W, 400, map width in pixels.
- MAP_H, 300, map height in pixels.
- AW, 17, framebuffer address width.

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  reset, asynchronous, active-high.
- i_cmd_valid  in  1  command valid.
- o_cmd_ready  out  1  engine idle, command accepted when valid&ready.
- i_x0, i_x1  in  9 each  rectangle column bounds, inclusive.
- i_y0, i_y1  in  9 each  rectangle row bounds, inclusive.
- i_color  in  3  fill colour {B,G,R}.
- i_mode  in  2  write mode: 0 replace, 1 and, 2 or, 3 xor.
- i_flush_req  in  1  single-cycle request to swap buffers.
- i_frame_end  in  1  single-cycle end-of-frame strobe from CRT timing.
- o_raddr  out  AW  back-buffer read address.
- i_rdata  in  3  back-buffer read data, valid 1 cycle after o_raddr.
- o_waddr  out  AW  write address.
- o_wdata  out  3  write data.
- o_we  out  1  write enable, one pixel per asserted cycle.
- o_flush  out  1  one-cycle swap pulse.
- o_busy  out  1  command or flush in progress.

Behaviour:
- Reset (async, active-high): state IDLE; o_cmd_ready=1 after release; o_we=0, o_flush=0, o_busy=0; o_waddr=o_raddr=0; o_wdata=0; flush-pending flag cleared.
- Reset mid-draw or mid-flush-wait aborts immediately. No further writes; pending flush discarded.
- Command latch on valid&ready:
  - If x0>x1 or y0>y1, swap the pair.
  - Clamp x to MAP_W-1 and y to MAP_H-1 after the swap.
  - o_cmd_ready drops the cycle after acceptance.
- Address arithmetic uses no multiplier:
  - row_base starts at y0*MAP_W, computed by repeated add in a SETUP state of y0 cycles. Max 299 cycles, a fixed cost.
  - Per row, row_base increments by MAP_W.
  - addr = row_base + x, truncated to AW bits. Max 119999 fits.
- States:
  - IDLE: accept a command, or go to FLUSH_WAIT if a flush is pending.
  - SETUP: compute row_base, then go to WRITE if mode=0, else READ.
  - WRITE (replace): o_we=1, o_wdata=color, o_waddr=addr. Exactly one pixel per cycle.
  - READ: drive o_raddr=addr, then go to MODIFY.
  - MODIFY: o_wdata = rop(i_rdata, color, mode), o_we=1, then go back to READ. Two cycles per pixel.
  - Pixel order is raster: x increments. At x=x1, x returns to x0 and the row increments. After the pixel at (x1,y1), go to IDLE, or to FLUSH_WAIT if a flush is pending.
  - FLUSH_WAIT: on the first i_frame_end, drive o_flush=1 for exactly one cycle, clear pending, go to IDLE.
- Pixel count:
  - Replace: exactly (x1-x0+1)*(y1-y0+1) write cycles.
  - Other modes: the same number of writes, spread over twice the cycles.
- Flush request handling:
  - i_flush_req sets pending in any state.
  - A flush is never issued while drawing. It waits for the current rectangle to complete.
  - Further requests while already pending merge into one flush.
- If i_flush_req and a command valid occur together in IDLE, the flush takes priority and the command is accepted after o_flush.
- i_frame_end during draw is ignored. A flush in FLUSH_WAIT waits for the next i_frame_end.
- o_busy = (state != IDLE) | pending.
- Degenerate rectangle (x0=x1, y0=y1) writes exactly one pixel.

Optional Feature:
- Macro DRAW_PIXCNT_EN.
- When defined:
  - Adds output o_pix_count [AW-1:0], counting o_we cycles since the last o_flush.
  - Cleared on reset and in the cycle o_flush=1.
  - Saturates at 2^AW-1.
- When undefined: the port and counter do not exist; all other behaviour is identical.

Decomposition:
- Package draw_pkg holds:
  - MAP_W, MAP_H, AW.
  - Enum wmode_t {WM_REPLACE, WM_AND, WM_OR, WM_XOR}.
  - Enum draw_state_t {IDLE, SETUP, WRITE, READ, MODIFY, FLUSH_WAIT}.
  - Struct draw_cmd_t for the latched command.
- Sub-module rop_unit: combinational raster op (old, color, mode) -> new. Replace=color, and=old&color, or=old|color, xor=old^color.

Test Plan:
- Replace, x0=0,x1=3,y0=0,y1=1, color=5 -> 8 writes, addrs 0..3 then 400..403, wdata=5, o_we contiguous for 8 cycles.
- XOR, x0=10,x1=10,y0=2,y1=2, color=7, i_rdata=3 -> o_raddr=810, then one write at 810 with wdata=4.
- Swapped/clamped bounds x0=450,x1=398,y0=299,y1=299, mode=replace -> writes addrs 119998,119999 only.
- i_flush_req mid-draw of a 4x4 rectangle, i_frame_end pulses during the draw and 20 cycles after it -> 16 writes complete, no o_flush until the post-draw i_frame_end, then exactly one pulse.
- Two i_flush_req plus a simultaneous command in IDLE -> one o_flush on the next i_frame_end, then the command is accepted.
- Assert reset during the write of pixel 5 of a 4x4 rectangle -> o_we=0 asynchronously, state IDLE, no o_flush. With DRAW_PIXCNT_EN, o_pix_count=0.

Source files
------------

// File: rtl/draw_pkg.sv
// Shared types and map geometry for the rectangle draw engine.
// Holds the write-mode and FSM enums plus the latched command bundle.
package draw_pkg;

    localparam int MAP_W = 400;
    localparam int MAP_H = 300;
    localparam int AW    = 17;

    localparam logic [AW-1:0] ROW_STEP = AW'(MAP_W);
    localparam logic [8:0]    X_MAX    = 9'(MAP_W - 1);
    localparam logic [8:0]    Y_MAX    = 9'(MAP_H - 1);

    typedef enum logic [1:0] {
        WM_REPLACE,
        WM_AND,
        WM_OR,
        WM_XOR
    } wmode_t;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        WRITE,
        READ,
        MODIFY,
        FLUSH_WAIT
    } draw_state_t;

    typedef struct packed {
        logic [8:0] x0;
        logic [8:0] x1;
        logic [8:0] y0;
        logic [8:0] y1;
        logic [2:0] color;
        wmode_t     mode;
    } draw_cmd_t;

    function automatic logic [8:0] clamp9(input logic [8:0] v, input logic [8:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/rop_unit.sv
// Combinational raster op: merges the fill colour into the old pixel.
// Replace ignores the old pixel; and/or/xor combine bitwise.
module rop_unit
    import draw_pkg::*;
(
    input  logic [2:0] old_px,
    input  logic [2:0] color,
    input  logic [1:0] mode,
    output logic [2:0] new_px
);

    always_comb begin
        new_px = color;
        unique case (wmode_t'(mode))
            WM_REPLACE: new_px = color;
            WM_AND:     new_px = old_px & color;
            WM_OR:      new_px = old_px | color;
            WM_XOR:     new_px = old_px ^ color;
            default:    new_px = color;
        endcase
    end

endmodule

// File: rtl/rect_draw_engine.sv
// Rectangle fill engine feeding the back buffer, with end-of-frame flush.
// Define DRAW_PIXCNT_EN to add the o_pix_count write counter port.
module rect_draw_engine
    import draw_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_cmd_valid,
    output logic          o_cmd_ready,
    input  logic [8:0]    i_x0,
    input  logic [8:0]    i_x1,
    input  logic [8:0]    i_y0,
    input  logic [8:0]    i_y1,
    input  logic [2:0]    i_color,
    input  logic [1:0]    i_mode,
    input  logic          i_flush_req,
    input  logic          i_frame_end,
    output logic [AW-1:0] o_raddr,
    input  logic [2:0]    i_rdata,
    output logic [AW-1:0] o_waddr,
    output logic [2:0]    o_wdata,
    output logic          o_we,
    output logic          o_flush,
    output logic          o_busy
`ifdef DRAW_PIXCNT_EN
    ,
    output logic [AW-1:0] o_pix_count
`endif
);

    draw_state_t   state, state_nx;
    draw_cmd_t     cmd, cmd_in;
    logic          pending;
    logic          flush_due;
    logic          accept;
    logic          last_px;
    logic [8:0]    x, y, ycnt;
    logic [8:0]    xa, xb, ya, yb;
    logic [AW-1:0] row_base;
    logic [AW-1:0] addr;
    logic [2:0]    rop_px;

    assign addr      = row_base + AW'(x);
    assign last_px   = (x == cmd.x1) && (y == cmd.y1);
    assign flush_due = pending | i_flush_req;

    // A same-cycle flush request outranks a new command.
    assign o_cmd_ready = (state == IDLE) & ~flush_due;
    assign accept      = i_cmd_valid & o_cmd_ready;
    assign o_busy      = (state != IDLE) | pending;

    always_comb begin
        xa = (i_x0 > i_x1) ? i_x1 : i_x0;
        xb = (i_x0 > i_x1) ? i_x0 : i_x1;
        ya = (i_y0 > i_y1) ? i_y1 : i_y0;
        yb = (i_y0 > i_y1) ? i_y0 : i_y1;
        cmd_in.x0    = clamp9(xa, X_MAX);
        cmd_in.x1    = clamp9(xb, X_MAX);
        cmd_in.y0    = clamp9(ya, Y_MAX);
        cmd_in.y1    = clamp9(yb, Y_MAX);
        cmd_in.color = i_color;
        cmd_in.mode  = wmode_t'(i_mode);
    end

    rop_unit u_rop (
        .old_px (i_rdata),
        .color  (cmd.color),
        .mode   (cmd.mode),
        .new_px (rop_px)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        o_we     = 1'b0;
        o_wdata  = '0;
        o_waddr  = '0;
        o_raddr  = '0;
        o_flush  = 1'b0;
        unique case (state)
            IDLE: begin
                if (flush_due)        state_nx = FLUSH_WAIT;
                else if (i_cmd_valid) state_nx = SETUP;
            end
            SETUP: begin
                if (ycnt == '0)
                    state_nx = (cmd.mode == WM_REPLACE) ? WRITE : READ;
            end
            WRITE: begin
                o_we    = 1'b1;
                o_wdata = cmd.color;
                o_waddr = addr;
                if (last_px) state_nx = flush_due ? FLUSH_WAIT : IDLE;
            end
            READ: begin
                o_raddr  = addr;
                state_nx = MODIFY;
            end
            MODIFY: begin
                o_we     = 1'b1;
                o_wdata  = rop_px;
                o_waddr  = addr;
                state_nx = READ;
                if (last_px) state_nx = flush_due ? FLUSH_WAIT : IDLE;
            end
            FLUSH_WAIT: begin
                if (i_frame_end) begin
                    o_flush  = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cmd      <= '0;
            pending  <= 1'b0;
            x        <= '0;
            y        <= '0;
            ycnt     <= '0;
            row_base <= '0;
        end else begin
            pending <= o_flush ? 1'b0 : flush_due;
            case (state)
                IDLE: begin
                    if (accept) begin
                        cmd      <= cmd_in;
                        x        <= cmd_in.x0;
                        y        <= cmd_in.y0;
                        ycnt     <= cmd_in.y0;
                        row_base <= '0;
                    end
                end
                // row_base = y0 * MAP_W built by repeated addition
                SETUP: begin
                    if (ycnt != '0) begin
                        row_base <= row_base + ROW_STEP;
                        ycnt     <= ycnt - 9'd1;
                    end
                end
                WRITE, MODIFY: begin
                    if (x == cmd.x1) begin
                        x <= cmd.x0;
                        if (y != cmd.y1) begin
                            y        <= y + 9'd1;
                            row_base <= row_base + ROW_STEP;
                        end
                    end else begin
                        x <= x + 9'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DRAW_PIXCNT_EN
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            o_pix_count <= '0;
        else if (o_flush)
            o_pix_count <= '0;
        else if (o_we && (o_pix_count != '1))
            o_pix_count <= o_pix_count + 1'b1;
    end
`endif

endmodule

// File: tb/tb_rect_draw_engine.sv
// Bench for rect_draw_engine: directed scenarios plus random rectangles.
// Expected pixel streams come from a frame-buffer model of the fill rules.
module tb_rect_draw_engine;
    import draw_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [8:0]    x0, x1, y0, y1;
    logic [2:0]    color;
    logic [1:0]    mode;
    logic          flush_req;
    logic          frame_end;
    logic [AW-1:0] raddr;
    logic [2:0]    rdata;
    logic [AW-1:0] waddr;
    logic [2:0]    wdata;
    logic          we;
    logic          flush;
    logic          busy;
`ifdef DRAW_PIXCNT_EN
    logic [AW-1:0] pix_count;
`endif

    always #5 clk = ~clk;

    rect_draw_engine dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_cmd_valid (cmd_valid),
        .o_cmd_ready (cmd_ready),
        .i_x0        (x0),
        .i_x1        (x1),
        .i_y0        (y0),
        .i_y1        (y1),
        .i_color     (color),
        .i_mode      (mode),
        .i_flush_req (flush_req),
        .i_frame_end (frame_end),
        .o_raddr     (raddr),
        .i_rdata     (rdata),
        .o_waddr     (waddr),
        .o_wdata     (wdata),
        .o_we        (we),
        .o_flush     (flush),
        .o_busy      (busy)
`ifdef DRAW_PIXCNT_EN
        ,
        .o_pix_count (pix_count)
`endif
    );

    function automatic logic [2:0] seed_px(input int a);
        if (a == 810) return 3'd3;
        return 3'(a * 5 + (a >> 4));
    endfunction

    // Back-buffer model: 1-cycle read latency, written by the DUT.
    logic [2:0] fb      [0:131071];
    bit         written [0:131071];
    always @(posedge clk) begin
        rdata <= written[raddr] ? fb[raddr] : seed_px(int'(raddr));
        if (we) begin
            fb[waddr]      <= wdata;
            written[waddr] <= 1'b1;
        end
    end

    // Observer of the write stream, flush pulses and read addresses.
    logic [19:0]   wq[$];
    int            wcyc[$];
    int            cyc = 0;
    int            flush_cnt = 0;
    int            flush_cyc = 0;
    logic [AW-1:0] last_raddr = '0;
    always @(negedge clk) begin
        if (we) begin
            wq.push_back({waddr, wdata});
            wcyc.push_back(cyc);
        end
        if (flush) begin
            flush_cnt++;
            flush_cyc = cyc;
        end
        if (raddr != '0) last_raddr = raddr;
        cyc++;
    end

    int          vectors = 0;
    int          miscompares = 0;
    logic [2:0]  ref_fb [0:131071];
    logic [19:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] rop_ref(input logic [2:0] old, input logic [2:0] c,
                                           input logic [1:0] m);
        case (m)
            2'd0:    return c;
            2'd1:    return old & c;
            2'd2:    return old | c;
            default: return old ^ c;
        endcase
    endfunction

    // Pixels in raster order after swap and clamp, with their final colour.
    task automatic model_cmd(input int ax0, input int ax1, input int ay0, input int ay1,
                             input logic [2:0] c, input logic [1:0] m);
        int lx, hx, ly, hy, a;
        lx = (ax0 < ax1) ? ax0 : ax1;
        hx = (ax0 < ax1) ? ax1 : ax0;
        ly = (ay0 < ay1) ? ay0 : ay1;
        hy = (ay0 < ay1) ? ay1 : ay0;
        if (lx > MAP_W - 1) lx = MAP_W - 1;
        if (hx > MAP_W - 1) hx = MAP_W - 1;
        if (ly > MAP_H - 1) ly = MAP_H - 1;
        if (hy > MAP_H - 1) hy = MAP_H - 1;
        exp_q.delete();
        for (int yy = ly; yy <= hy; yy++)
            for (int xx = lx; xx <= hx; xx++) begin
                a = yy * MAP_W + xx;
                exp_q.push_back({17'(a), rop_ref(ref_fb[a], c, m)});
            end
    endtask

    task automatic apply_model(input int n);
        for (int i = 0; i < n && i < exp_q.size(); i++)
            ref_fb[int'(exp_q[i][19:3])] = exp_q[i][2:0];
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_cmd(input int ax0, input int ax1, input int ay0, input int ay1,
                             input logic [2:0] c, input logic [1:0] m);
        x0 = 9'(ax0); x1 = 9'(ax1); y0 = 9'(ay0); y1 = 9'(ay1);
        color = c; mode = m; cmd_valid = 1'b1;
        model_cmd(ax0, ax1, ay0, ay1, c, m);
    endtask

    task automatic await_accept(input string tag);
        int t = 0;
        @(negedge clk);
        while (!cmd_ready && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_accept"}, 32'(cmd_ready), 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_ready_drop"}, 32'(cmd_ready), 0);
    endtask

    task automatic wait_idle(input string tag);
        int t = 0;
        while (busy && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_idle"}, 32'(busy), 0);
        step(1);
    endtask

    task automatic wait_writes(input int target, input string tag);
        int t = 0;
        while (wq.size() < target && t < 1000) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk({tag, "_wcount_reached"}, 32'(wq.size() >= target), 1);
    endtask

    task automatic check_writes(input int base, input int n, input int spacing,
                                input string tag);
        chk({tag, "_nwrites"}, 32'(wq.size() - base), 32'(n));
        for (int i = 0; i < n && base + i < wq.size(); i++) begin
            chk($sformatf("%s_addr%0d", tag, i), 32'(wq[base+i][19:3]), 32'(exp_q[i][19:3]));
            chk($sformatf("%s_data%0d", tag, i), 32'(wq[base+i][2:0]), 32'(exp_q[i][2:0]));
        end
        if (spacing > 0 && n > 0 && wq.size() >= base + n)
            chk({tag, "_cadence"}, 32'(wcyc[base+n-1] - wcyc[base]), 32'(spacing * (n - 1)));
    endtask

    task automatic run_cmd(input int ax0, input int ax1, input int ay0, input int ay1,
                           input logic [2:0] c, input logic [1:0] m, input string tag);
        int base;
        base = wq.size();
        drive_cmd(ax0, ax1, ay0, ay1, c, m);
        await_accept(tag);
        wait_idle(tag);
        check_writes(base, exp_q.size(), (m == 2'd0) ? 1 : 2, tag);
        apply_model(exp_q.size());
    endtask

    initial begin
        int base, fc;
        int rx0, rx1, ry0, ry1;
        for (int i = 0; i < 131072; i++) ref_fb[i] = seed_px(i);
        rst = 1'b1; cmd_valid = 1'b0; flush_req = 1'b0; frame_end = 1'b0;
        x0 = '0; x1 = '0; y0 = '0; y1 = '0; color = '0; mode = '0;

        @(negedge clk);
        chk("rst_we", 32'(we), 0);
        chk("rst_flush", 32'(flush), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_waddr", 32'(waddr), 0);
        chk("rst_raddr", 32'(raddr), 0);
        chk("rst_wdata", 32'(wdata), 0);
`ifdef DRAW_PIXCNT_EN
        chk("rst_pixcnt", 32'(pix_count), 0);
`endif
        #2 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(cmd_ready), 1);
        step(1);

        run_cmd(0, 3, 0, 1, 3'd5, 2'd0, "replace4x2");

        run_cmd(10, 10, 2, 2, 3'd7, 2'd3, "xor_1px");
        chk("xor_raddr", 32'(last_raddr), 810);

        run_cmd(450, 398, 299, 299, 3'd6, 2'd0, "swap_clamp");

        // Flush requested mid-draw waits for the rectangle and the next frame end.
        base = wq.size();
        fc = flush_cnt;
        drive_cmd(20, 23, 0, 3, 3'd2, 2'd0);
        await_accept("flush_mid");
        wait_writes(base + 1, "flush_mid_start");
        step(1);
        flush_req = 1'b1;
        step(1);
        flush_req = 1'b0;
        frame_end = 1'b1;
        step(1);
        frame_end = 1'b0;
        wait_writes(base + 16, "flush_mid_draw");
        step(2);
        chk("flush_mid_no_early", 32'(flush_cnt - fc), 0);
        chk("flush_mid_busy_pending", 32'(busy), 1);
        step(20);
        chk("flush_mid_still_wait", 32'(flush_cnt - fc), 0);
        frame_end = 1'b1;
        step(1);
        frame_end = 1'b0;
        step(1);
        chk("flush_mid_one_pulse", 32'(flush_cnt - fc), 1);
        chk("flush_mid_idle", 32'(busy), 0);
        check_writes(base, 16, 1, "flush_mid");
        apply_model(16);
`ifdef DRAW_PIXCNT_EN
        chk("flush_mid_pixcnt_clr", 32'(pix_count), 0);
`endif

        // Merged flush requests with a simultaneous command: flush first.
        base = wq.size();
        fc = flush_cnt;
        flush_req = 1'b1;
        drive_cmd(5, 7, 3, 3, 3'd4, 2'd2);
        @(negedge clk);
        chk("prio_ready_low", 32'(cmd_ready), 0);
        step(1);
        flush_req = 1'b0;
        step(2);
        flush_req = 1'b1;
        step(1);
        flush_req = 1'b0;
        step(3);
        chk("prio_no_writes", 32'(wq.size() - base), 0);
        chk("prio_no_flush_yet", 32'(flush_cnt - fc), 0);
        frame_end = 1'b1;
        step(1);
        frame_end = 1'b0;
        await_accept("prio");
        wait_idle("prio");
        chk("prio_one_flush", 32'(flush_cnt - fc), 1);
        check_writes(base, exp_q.size(), 2, "prio");
        if (wq.size() > base)
            chk("prio_flush_before_draw", 32'(flush_cyc < wcyc[base]), 1);
        apply_model(exp_q.size());
`ifdef DRAW_PIXCNT_EN
        chk("prio_pixcnt", 32'(pix_count), 3);
`endif

        // Reset during pixel 5 aborts writes and drops the pending flush.
        base = wq.size();
        fc = flush_cnt;
        drive_cmd(100, 103, 0, 3, 3'd1, 2'd0);
        await_accept("abort");
        wait_writes(base + 1, "abort_start");
        step(1);
        flush_req = 1'b1;
        step(1);
        flush_req = 1'b0;
        wait_writes(base + 5, "abort_px5");
        chk("abort_we_before", 32'(we), 1);
        rst = 1'b1;
        #1;
        chk("abort_we_async", 32'(we), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_ready", 32'(cmd_ready), 1);
`ifdef DRAW_PIXCNT_EN
        chk("abort_pixcnt", 32'(pix_count), 0);
`endif
        step(2);
        rst = 1'b0;
        step(2);
        frame_end = 1'b1;
        step(1);
        frame_end = 1'b0;
        step(5);
        chk("abort_no_flush", 32'(flush_cnt - fc), 0);
        check_writes(base, 5, 1, "abort");
        apply_model(5);

        for (int k = 0; k < 12; k++) begin
            rx0 = $urandom_range(0, 505);
            rx1 = rx0 + $urandom_range(0, 5);
            ry0 = $urandom_range(0, 505);
            ry1 = ry0 + $urandom_range(0, 4);
            if ($urandom_range(0, 1) == 1) begin
                rx0 = rx0 ^ rx1; rx1 = rx0 ^ rx1; rx0 = rx0 ^ rx1;
            end
            if ($urandom_range(0, 1) == 1) begin
                ry0 = ry0 ^ ry1; ry1 = ry0 ^ ry1; ry0 = ry0 ^ ry1;
            end
            run_cmd(rx0, rx1, ry0, ry1, 3'($urandom_range(0, 7)),
                    2'($urandom_range(0, 3)), $sformatf("rand%0d", k));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
